pmem_arbiter: RTL
=================

# pmem_arbiter

Parametrised round-robin arbiter that multiplexes NUM_CH cache-line requesters (I-cache, D-cache, prefetcher, ...) onto the single physical-memory (pmem) port. Each channel and the pmem side use the same read/write/resp line handshake. The block sits between the cache hierarchy and the pmem model/controller and serialises one line transaction at a time.

## Interface
- NUM_CH, 2: number of requester channels, 2..8.
- ADDR_W, 32: address width.
- LINE_W, 256: line data width.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_read  in  NUM_CH  per-channel line read request.
- ch_write  in  NUM_CH  per-channel line write request.
- ch_address  in  NUM_CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  channel i at bits [i*LINE_W +: LINE_W].
- ch_rdata  out  LINE_W  read data, shared by all channels, valid with ch_resp.
- ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot.
- pmem_read  out  1  pmem read request.
- pmem_write  out  1  pmem write request.
- pmem_address  out  ADDR_W  pmem line address.
- pmem_wdata  out  LINE_W  pmem write data.
- pmem_rdata  in  LINE_W  pmem read data, valid with pmem_resp.
- pmem_resp  in  1  pmem completion.
- arb_err  out  1  sticky protocol error (see Configuration).

## Operation
- Requester protocol: hold ch_read or ch_write, address and wdata stable until ch_resp; then drop or issue anew.
- FSM states IDLE, ISSUE, RESP.
- IDLE: if any channel requests, pick winner = first requesting channel at or after rr_ptr, wrapping modulo NUM_CH. Latch grant id, op (write wins if both asserted), address, wdata. Go ISSUE. No request: stay IDLE.
- ISSUE: drive pmem_read/pmem_write from latched op, pmem_address/pmem_wdata from latched regs. Held constant until pmem_resp. On pmem_resp: capture pmem_rdata into rdata_q (reads only; writes leave rdata_q unchanged), go RESP.
- RESP: ch_resp[grant]=1, ch_rdata=rdata_q; rr_ptr <= (grant+1) mod NUM_CH; go IDLE.
- pmem_read/pmem_write are 0 outside ISSUE; ch_resp is 0 outside RESP.
- pmem_resp outside ISSUE is ignored (flagged under checker).
- Non-granted channels wait; round-robin guarantees each requester is served within NUM_CH transactions.
- Reset (any time, including mid-ISSUE): state IDLE, rr_ptr=0, all outputs 0, rdata_q=0, latches 0, arb_err=0. Abandoned pmem transaction is not resumed.

## Timing
- Request visible in IDLE at cycle t -> pmem_read/write high from t+1.
- pmem_resp in cycle k -> ch_resp high in cycle k+1 exactly one cycle.
- Minimum channel latency: 3 cycles (pmem_resp same cycle as first ISSUE cycle).
- Back-to-back: next IDLE arbitration at k+2; a channel's request held through its RESP cycle is not re-granted because it deasserts at the end of that cycle.
- Outputs are registered or decoded from state/latched regs only; no combinational path from ch_* or pmem_resp to any output.

## Configuration
- PMEM_ARB_CHECK_EN defined: protocol checker sets arb_err (sticky until rst) on: any channel with ch_read and ch_write both high; granted channel dropping its request or changing ch_address during ISSUE; pmem_resp high in IDLE or RESP.
- Undefined: checker absent, arb_err tied 0; write-wins rule still applies.

## Test plan
- NUM_CH=2; ch0 read 0x0000_1000, pmem_resp after 4 ISSUE cycles with rdata=0xA5..A5 -> pmem_read high 4 cycles, pmem_address=0x1000, ch_resp=2'b01 one cycle later, ch_rdata=0xA5..A5.
- ch0 read and ch1 write asserted same cycle after reset -> ch0 served first, then ch1 (pmem_write, address/wdata of ch1); next simultaneous pair served ch1 first? No: rr_ptr=0 after ch1 -> ch0 first again; alternation verified over 8 transactions with both always requesting: grants 0,1,0,1,...
- NUM_CH=4, channels 1 and 3 continuously requesting, rr_ptr=2 -> grants 3,1,3,1.
- rst asserted mid-ISSUE -> pmem_read drops to 0 asynchronously, arb_err=0, ch_resp=0; after release ch0 re-request completes normally.
- With PMEM_ARB_CHECK_EN: ch1 drives both read and write -> write issued, arb_err=1 and stays 1 until rst; spurious pmem_resp in IDLE -> arb_err=1, no ch_resp pulse.
- Without PMEM_ARB_CHECK_EN: same stimuli -> arb_err stays 0, write issued.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - channel-side and pmem-side line handshake bundle for pmem_arbiter
interface pmem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     pmem_read;
    logic                     pmem_write;
    logic [ADDR_W-1:0]        pmem_address;
    logic [LINE_W-1:0]        pmem_wdata;
    logic [LINE_W-1:0]        pmem_rdata;
    logic                     pmem_resp;
    logic                     arb_err;

    // Arbiter view: serves the requesters, masters the pmem port.
    modport slave (
        input  ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
        output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, arb_err
    );

    // Environment view: requesters plus the pmem model.
    modport master (
        output ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
        input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, arb_err
    );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter serialising NUM_CH line requesters onto one pmem port
// Optional protocol checker driving arb_err is enabled by defining PMEM_ARB_CHECK_EN.
module pmem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic          clk,
    input  logic          rst,
    pmem_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_q;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    idx;
    logic                winner_vld;
    logic                op_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q;
    logic [NUM_CH-1:0]   req;

    assign req = bus.ch_read | bus.ch_write;

    // Scan from the highest offset down so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        winner     = '0;
        winner_vld = 1'b0;
        idx        = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = PTR_W'((int'(rr_ptr) + off) % NUM_CH);
            if (req[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (winner_vld) state_nxt = ISSUE;
            ISSUE:   if (bus.pmem_resp) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && winner_vld) begin
                grant_q    <= winner;
                op_write_q <= bus.ch_write[winner];
                addr_q     <= bus.ch_address[int'(winner)*ADDR_W +: ADDR_W];
                wdata_q    <= bus.ch_wdata[int'(winner)*LINE_W +: LINE_W];
            end
            // Writes complete without touching the shared read-data register.
            if (state == ISSUE && bus.pmem_resp && !op_write_q) begin
                rdata_q <= bus.pmem_rdata;
            end
            if (state == RESP) begin
                rr_ptr <= (grant_q == PTR_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign bus.pmem_read    = (state == ISSUE) && !op_write_q;
    assign bus.pmem_write   = (state == ISSUE) && op_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.ch_rdata     = rdata_q;

    always_comb begin
        bus.ch_resp = '0;
        if (state == RESP) begin
            bus.ch_resp[grant_q] = 1'b1;
        end
    end

`ifdef PMEM_ARB_CHECK_EN
    logic err_q;
    logic err_now;

    always_comb begin
        err_now = |(bus.ch_read & bus.ch_write);
        if (state == ISSUE &&
            (!req[grant_q] || bus.ch_address[int'(grant_q)*ADDR_W +: ADDR_W] != addr_q)) begin
            err_now = 1'b1;
        end
        if (state != ISSUE && bus.pmem_resp) begin
            err_now = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign bus.arb_err = err_q;
`else
    assign bus.arb_err = 1'b0;
`endif
endmodule
